// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and
// the instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a request/ready bus,
// holds the instruction until commit, then advances the PC by jump/branch/+4.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master imem,
  input  logic         commit,
  input  logic         pcsrc,
  input  logic         jump,
  input  logic [31:0]  signimm,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [5:0]   op,
  output logic [5:0]   funct,
  output logic [31:0]  pc,
  output logic [31:0]  pcplus4,
  output logic [31:0]  retired
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        valid_q, valid_d;
  logic [31:0] pcplus4_w;
  logic [31:0] next_pc;

  assign pcplus4_w = pc_q + 32'd4;

  // Jump outranks a taken branch when the controller raises both.
  always_comb begin
    next_pc = pcplus4_w;
    if (jump) begin
      next_pc = {pcplus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc = pcplus4_w + (signimm << 2);
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    retired_d     = retired_q;
    imem.imem_req = 1'b0;
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (commit) begin
          pc_d      = next_pc;
          valid_d   = 1'b0;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      default: state_d = START;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= START;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      valid_q   <= 1'b0;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      retired_q <= retired_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign op             = instr_q[31:26];
  assign funct          = instr_q[5:0];
  assign pc             = pc_q;
  assign pcplus4        = pcplus4_w;
  assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        commit, pcsrc, jump;
  logic [31:0] signimm;
  logic [31:0] instr, pc, pcplus4, retired;
  logic        instr_valid;
  logic [5:0]  op, funct;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem       (bus.master),
    .commit     (commit),
    .pcsrc      (pcsrc),
    .jump       (jump),
    .signimm    (signimm),
    .instr      (instr),
    .instr_valid(instr_valid),
    .op         (op),
    .funct      (funct),
    .pc         (pc),
    .pcplus4    (pcplus4),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = waiting one cycle after reset, 1 = request
  // outstanding, 2 = instruction held for the datapath.
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_ret;
  logic        m_valid;

  function automatic logic [31:0] model_next_pc(logic [31:0] cur_pc, logic [31:0] held,
                                                logic j, logic b, logic [31:0] imm);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (j)      return (seq & 32'hF000_0000) | ((held & 32'h03FF_FFFF) * 32'd4);
    else if (b) return seq + imm * 32'd4;
    else        return seq;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pc    = RST_PC;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_ret   = 32'h0;
  endtask

  task automatic model_edge();
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus.imem_ready) begin
        m_instr = bus.imem_rdata;
        m_valid = 1'b1;
        m_phase = 2;
      end
    end else if (commit) begin
      m_pc    = model_next_pc(m_pc, m_instr, jump, pcsrc, signimm);
      m_valid = 1'b0;
      m_ret   = m_ret + 32'd1;
      m_phase = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    check("imem_req",    32'(bus.imem_req), 32'(m_phase == 1));
    check("imem_addr",   bus.imem_addr, m_pc);
    check("pc",          pc, m_pc);
    check("pcplus4",     pcplus4, m_pc + 32'd4);
    check("instr",       instr, m_instr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("op",          32'(op), m_instr >> 26);
    check("funct",       32'(funct), m_instr % 32'd64);
    check("retired",     retired, m_ret);
  endtask

  // Inputs change only at the falling edge; outputs are compared there too.
  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic go(input logic b, input logic j, input logic [31:0] imm, input logic [31:0] rd);
    pcsrc          = b;
    jump           = j;
    signimm        = imm;
    bus.imem_rdata = rd;
    step();
  endtask

  task automatic rand_inputs();
    commit         = ($urandom_range(0, 1) == 1);
    bus.imem_ready = ($urandom_range(0, 9) < 6);
    jump           = ($urandom_range(0, 4) == 0);
    pcsrc          = ($urandom_range(0, 2) == 0);
    signimm        = $urandom;
    bus.imem_rdata = $urandom;
  endtask

  task automatic reset_in_phase(input int phase, input string tag);
    int n = 0;
    while (m_phase != phase && n < 200) begin
      rand_inputs();
      if (phase == 1) bus.imem_ready = 1'b0;
      step();
      n++;
    end
    check({tag, "_reached"}, 32'(m_phase), 32'(phase));
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_req"},     32'(bus.imem_req), 32'h0);
    check({tag, "_pc"},      pc, RST_PC);
    check({tag, "_instr"},   instr, 32'h0);
    check({tag, "_valid"},   32'(instr_valid), 32'h0);
    check({tag, "_retired"}, retired, 32'h0);
    commit = 1'b1; bus.imem_ready = 1'b1;
    step();
    commit = 1'b0; bus.imem_ready = 1'b0;
    step();
    // Release with both commit and ready high: the START cycle must ignore them.
    commit = 1'b1; bus.imem_ready = 1'b1; jump = 1'b0; pcsrc = 1'b0;
    reset_n = 1'b1;
    step();
    check({tag, "_restart_req"},   32'(bus.imem_req), 32'h1);
    check({tag, "_restart_addr"},  bus.imem_addr, RST_PC);
    check({tag, "_restart_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_restart_ret"},   retired, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    commit = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    model_reset();
    step();
    step();
    check("rst_pc",      pc, 32'h0040_0000);
    check("rst_req",     32'(bus.imem_req), 32'h0);
    check("rst_retired", retired, 32'h0);

    // Zero-wait memory, commit held high, sequential flow.
    commit = 1'b1; bus.imem_ready = 1'b1;
    reset_n = 1'b1;
    step();
    check("seq_addr0", bus.imem_addr, 32'h0040_0000);
    check("seq_req0",  32'(bus.imem_req), 32'h1);
    step();
    check("seq_gap0",  32'(bus.imem_req), 32'h0);
    check("seq_valid", 32'(instr_valid), 32'h1);
    step();
    check("seq_addr1", bus.imem_addr, 32'h0040_0004);
    step();
    check("seq_gap1",  32'(bus.imem_req), 32'h0);
    step();
    check("seq_addr2", bus.imem_addr, 32'h0040_0008);
    step();
    // Third commit uses jump with a zero held instruction: target 0.
    bus.imem_ready = 1'b0;
    go(1'b0, 1'b1, 32'h0, 32'h0000_0020);
    check("seq_retired3", retired, 32'd3);
    commit = 1'b0; jump = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check("wait_req",  32'(bus.imem_req), 32'h1);
      check("wait_addr", bus.imem_addr, 32'h0);
      if (w == 3) bus.imem_ready = 1'b1;
      step();
    end
    check("wait_valid", 32'(instr_valid), 32'h1);
    check("wait_op",    32'(op), 32'h0);
    check("wait_funct", 32'(funct), 32'h20);

    // Branch / jump / wrap chain with commit and ready held high.
    commit = 1'b1;
    go(1'b1, 1'b0, 32'h0000_0003, 32'hDEAD_BEEF);
    check("br_to_10", bus.imem_addr, 32'h0000_0010);
    go(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);
    go(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);
    check("br_neg", bus.imem_addr, 32'h0000_0004);
    go(1'b1, 1'b0, 32'h03FF_FFFE, 32'h0);
    go(1'b1, 1'b0, 32'h03FF_FFFE, 32'h0);
    check("br_far", bus.imem_addr, 32'h1000_0000);
    go(1'b1, 1'b1, 32'h3BFF_FFFA, 32'h0800_0004);
    check("jmp_instr", instr, 32'h0800_0004);
    go(1'b1, 1'b1, 32'h3BFF_FFFA, 32'h0);
    check("jmp_wins", bus.imem_addr, 32'h1000_0010);
    go(1'b1, 1'b0, 32'h3BFF_FFFA, 32'h0);
    go(1'b1, 1'b0, 32'h3BFF_FFFA, 32'h0);
    check("to_top", bus.imem_addr, 32'hFFFF_FFFC);
    go(1'b0, 1'b0, 32'h0, 32'h0);
    go(1'b0, 1'b0, 32'h0, 32'h0);
    check("pc_wrap", bus.imem_addr, 32'h0000_0000);
    check("chain_retired", retired, 32'd9);

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      step();
    end

    reset_in_phase(1, "rst_fetch");
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end
    reset_in_phase(2, "rst_hold");
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
